// File: rtl/mmp_iddmm_ctrl.sv
// mmp_iddmm_ctrl: sequencer wrapped around one mmp_iddmm_pe.
//
// Runs the i/j word loops of the interleaved Montgomery multiplication and
// drives the PE control strobes. It owns the (N+1)-word intermediate buffer A.
// The j index is delayed by the PE latency so that each uj word returned by
// the PE is written back into A. After the last row the final PE carry is
// captured into A[N], and the N-word result is streamed out over a
// valid/ready port.
//
// Configuration macro MMP_IDDMM_CTRL_FINALSUB_EN:
//   defined   - a CMP pass computes the borrow of A-M, and the output stream
//               carries A-M when A >= M, otherwise A.
//   undefined - A is streamed unmodified, and res_ovf (= A[N][0]) is valid
//               alongside res_valid.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start/busy/done     host handshake; start is ignored unless idle
//   i_idx               y-word index to the external y memory
//   j_idx, mj           x/m-word index and the m word read at that index
//   aj, uj, carry       A[j_idx] to the PE; PE result word and carry
//   ctl_*               PE control strobes (all 0 outside Q/ROW)
//   res_valid/ready     result stream handshake
//   res_idx, res_data   result word index and data
//   res_ovf             top bit of the result (only without final subtraction)

module mmp_iddmm_ctrl #(
  parameter int K   = 128,
  parameter int N   = 32,
  parameter int LAT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(N)-1:0]   i_idx,
  output logic [$clog2(N):0]     j_idx,
  input  logic [K-1:0]           mj,
  output logic [K-1:0]           aj,
  input  logic [K-1:0]           uj,
  input  logic                   carry,
  output logic                   ctl_carry_clr,
  output logic                   ctl_carry_ena,
  output logic                   ctl_carry_sel,
  output logic                   ctl_c_pre_clr,
  output logic                   ctl_q_ena,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [$clog2(N)-1:0]   res_idx,
  output logic [K-1:0]           res_data
`ifdef MMP_IDDMM_CTRL_FINALSUB_EN
`else
  ,
  output logic                   res_ovf
`endif
);

  localparam int IW = $clog2(N);
  localparam int JW = IW + 1;
  localparam logic [JW-1:0] J_LAST     = JW'(N);
  localparam logic [JW-1:0] J_OUT_LAST = JW'(N - 1);
  localparam logic [JW-1:0] J_DRN_LAST = JW'(LAT - 1);
  localparam logic [IW-1:0] I_LAST     = IW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_Q, S_ROW, S_DRAIN, S_CARRY, S_CMP, S_OUT, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   i_q, i_d;
  logic [JW-1:0]   j_q, j_d;
  logic [K-1:0]    a_q [N+1];
  logic [K-1:0]    a_d [N+1];
  logic [JW-1:0]   dl_q [LAT];
  logic [JW-1:0]   dl_d [LAT];
  logic [JW-1:0]   jw;
  logic [JW-1:0]   j_out;
  logic [K-1:0]    a_rd;

`ifdef MMP_IDDMM_CTRL_FINALSUB_EN
  logic            b_q, b_d;
  logic            ge_q, ge_d;
  logic [K-1:0]    m_eff;
  logic [K:0]      sub;
`else
  logic            unused_mj;
  assign unused_mj = ^mj;
`endif

  // In DRAIN j_q counts the drain cycles, but the memory index stays at 0.
  assign j_out = (state_q == S_DRAIN) ? '0 : j_q;
  assign a_rd  = a_q[j_out];
  assign jw    = dl_q[LAT-1];

`ifdef MMP_IDDMM_CTRL_FINALSUB_EN
  // One K-bit word of A-M per cycle; the top bit of sub is the borrow out.
  // M[N] is taken as 0 whatever the m memory returns at index N.
  assign m_eff = (j_q == J_LAST) ? '0 : mj;
  assign sub   = {1'b0, a_rd} - {1'b0, m_eff} - (K+1)'(b_q);
`endif

  // NOTE: every signal assigned in this block gets a default first, so that
  // no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    a_d     = a_q;
`ifdef MMP_IDDMM_CTRL_FINALSUB_EN
    b_d     = b_q;
    ge_d    = ge_q;
`endif

    // j delay line. Only Q/ROW issue j; the j=0 entries (Q cycle, ROW j=0,
    // and drain) never write, because uj lags the issued j by one word.
    dl_d[0] = (state_q == S_Q || state_q == S_ROW) ? j_q : '0;
    for (int k = 1; k < LAT; k++) dl_d[k] = dl_q[k-1];
    if (jw != '0) a_d[jw - JW'(1)] = uj;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_Q;
          i_d     = '0;
          j_d     = '0;
        end
      end
      S_Q: begin
        state_d = S_ROW;
        j_d     = '0;
      end
      S_ROW: begin
        if (j_q == J_LAST) begin
          j_d = '0;
          if (i_q == I_LAST) begin
            state_d = S_DRAIN;
          end else begin
            i_d     = i_q + IW'(1);
            state_d = S_Q;
          end
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      S_DRAIN: begin
        if (j_q == J_DRN_LAST) begin
          j_d     = '0;
          state_d = S_CARRY;
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      S_CARRY: begin
        a_d[N] = {{(K-1){1'b0}}, carry};
        j_d    = '0;
`ifdef MMP_IDDMM_CTRL_FINALSUB_EN
        b_d     = 1'b0;
        state_d = S_CMP;
`else
        state_d = S_OUT;
`endif
      end
      S_CMP: begin
`ifdef MMP_IDDMM_CTRL_FINALSUB_EN
        b_d = sub[K];
        if (j_q == J_LAST) begin
          ge_d    = ~sub[K];
          b_d     = 1'b0;
          j_d     = '0;
          state_d = S_OUT;
        end else begin
          j_d = j_q + JW'(1);
        end
`else
        state_d = S_OUT;
`endif
      end
      S_OUT: begin
        if (res_ready) begin
`ifdef MMP_IDDMM_CTRL_FINALSUB_EN
          b_d = sub[K];
`endif
          if (j_q == J_OUT_LAST) begin
            j_d     = '0;
            state_d = S_DONE;
          end else begin
            j_d = j_q + JW'(1);
          end
        end
      end
      S_DONE: begin
        for (int k = 0; k <= N; k++) a_d[k] = '0;
        i_d     = '0;
        j_d     = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so that every flop samples the
  // values from before the edge, independent of statement order.
  // NOTE: the A buffer and the delay line are reset explicitly. A reset in
  // the middle of an operation must not leave stale words, and no later write
  // can be relied on to clear them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      for (int k = 0; k <= N; k++) a_q[k] <= '0;
      for (int k = 0; k < LAT; k++) dl_q[k] <= '0;
`ifdef MMP_IDDMM_CTRL_FINALSUB_EN
      b_q  <= 1'b0;
      ge_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      a_q     <= a_d;
      dl_q    <= dl_d;
`ifdef MMP_IDDMM_CTRL_FINALSUB_EN
      b_q  <= b_d;
      ge_q <= ge_d;
`endif
    end
  end

  assign busy  = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done  = (state_q == S_DONE);
  assign i_idx = i_q;
  assign j_idx = j_out;
  assign aj    = a_rd;

  assign ctl_c_pre_clr = (state_q == S_Q);
  assign ctl_q_ena     = (state_q == S_Q);
  assign ctl_carry_clr = (i_q == '0) &&
                         ((state_q == S_Q) || (state_q == S_ROW && j_q == '0));
  assign ctl_carry_ena = (state_q == S_ROW) && (j_q == J_LAST);
  assign ctl_carry_sel = ctl_carry_ena;

  assign res_valid = (state_q == S_OUT);
  assign res_idx   = res_valid ? j_q[IW-1:0] : '0;
`ifdef MMP_IDDMM_CTRL_FINALSUB_EN
  assign res_data  = !res_valid ? '0 : (ge_q ? sub[K-1:0] : a_rd);
`else
  assign res_data  = res_valid ? a_rd : '0;
  assign res_ovf   = res_valid ? a_q[N][0] : 1'b0;
`endif

endmodule

// File: tb/tb_mmp_iddmm_ctrl.sv
// Directed bench for mmp_iddmm_ctrl at K=8, N=2.
// The dut1 instance (LAT=1) sits on a stub PE whose uj/carry come from a
// scenario mode. It covers the equal / pass-through / subtract results,
// latency, start handling, backpressure and reset. The dut2 instance (LAT=2)
// has its strobes and indices checked cycle by cycle.

module tb_mmp_iddmm_ctrl;

  localparam int K = 8;
  localparam int N = 2;
`ifdef MMP_IDDMM_CTRL_FINALSUB_EN
  localparam int CMP_CYC = N + 1;
`else
  localparam int CMP_CYC = 0;
`endif
  // Cycles from the start-accepting edge until done is visible.
  localparam int EXP_LAT1 = N*(N+2) + 1 + 1 + CMP_CYC + N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int mode_r   = 0;

  // dut1 signals
  logic       start1 = 1'b0, busy1, done1;
  logic [0:0] i_idx1;
  logic [1:0] j_idx1, jd1;
  logic [7:0] mj1, aj1, uj1;
  logic       carry1;
  logic       clr1, ena1, sel1, pre1, qen1;
  logic       res_valid1, res_ready1 = 1'b1;
  logic [0:0] res_idx1;
  logic [7:0] res_data1;
  logic       res_ovf1;

  // dut2 signals
  logic       start2 = 1'b0, busy2, done2;
  logic [0:0] i_idx2;
  logic [1:0] j_idx2;
  logic [7:0] aj2;
  logic       clr2, ena2, sel2, pre2, qen2;
  logic       res_valid2;
  logic [0:0] res_idx2;
  logic [7:0] res_data2;
  logic       res_ovf2;

  // m memory: M = 0xF0C5; index 2 returns garbage that the DUT must ignore.
  assign mj1 = (j_idx1 == 2'd0) ? 8'hC5 : (j_idx1 == 2'd1) ? 8'hF0 : 8'hAA;

  // Stub PE with latency 1: the returned word depends on the delayed index.
  always @(posedge clk) jd1 <= j_idx1;
  assign uj1 = (mode_r == 0) ? ((jd1 == 2'd1) ? 8'hC5 : 8'hF0) :
               (mode_r == 1) ? 8'h10 : 8'hFF;
  assign carry1 = (mode_r == 2);

  mmp_iddmm_ctrl #(.K(K), .N(N), .LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .i_idx(i_idx1), .j_idx(j_idx1), .mj(mj1), .aj(aj1), .uj(uj1),
    .carry(carry1), .ctl_carry_clr(clr1), .ctl_carry_ena(ena1),
    .ctl_carry_sel(sel1), .ctl_c_pre_clr(pre1), .ctl_q_ena(qen1),
    .res_valid(res_valid1), .res_ready(res_ready1), .res_idx(res_idx1),
    .res_data(res_data1)
`ifdef MMP_IDDMM_CTRL_FINALSUB_EN
`else
    , .res_ovf(res_ovf1)
`endif
  );

  mmp_iddmm_ctrl #(.K(K), .N(N), .LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .i_idx(i_idx2), .j_idx(j_idx2), .mj(8'h00), .aj(aj2), .uj(8'h00),
    .carry(1'b0), .ctl_carry_clr(clr2), .ctl_carry_ena(ena2),
    .ctl_carry_sel(sel2), .ctl_c_pre_clr(pre2), .ctl_q_ena(qen2),
    .res_valid(res_valid2), .res_ready(1'b1), .res_idx(res_idx2),
    .res_data(res_data2)
`ifdef MMP_IDDMM_CTRL_FINALSUB_EN
`else
    , .res_ovf(res_ovf2)
`endif
  );

`ifdef MMP_IDDMM_CTRL_FINALSUB_EN
  assign res_ovf1 = 1'b0;
  assign res_ovf2 = 1'b0;
`endif

  function automatic logic [31:0] outs1();
    return {busy1, done1, res_valid1, i_idx1, j_idx1, res_idx1, res_data1,
            aj1, clr1, ena1, sel1, pre1, qen1, res_ovf1};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (outs1() !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_outs1: got %h want 0", outs1());
    end
    n_checks++;
    if ({busy2, done2, res_valid2, qen2, clr2, j_idx2} !== 7'd0) begin
      n_errors++;
      $display("FAIL reset_outs2: got %b want 0",
               {busy2, done2, res_valid2, qen2, clr2, j_idx2});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One full operation on dut1 with res_ready=1. Also pokes start while busy
  // and in the DONE cycle; neither pulse may launch another operation.
  task automatic test_run(input int mode, input logic [7:0] e0,
                          input logic [7:0] e1, input logic eovf,
                          input string name);
    logic [7:0] got0, got1;
    logic       gotovf;
    int         edges;
    mode_r     = mode;
    res_ready1 = 1'b1;
    got0 = 8'hxx; got1 = 8'hxx; gotovf = 1'bx;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    edges  = 0;
    n_checks++;
    if (busy1 !== 1'b1) begin
      n_errors++;
      $display("FAIL %s_busy: got %b want 1", name, busy1);
    end
    while (!done1 && edges < 100) begin
      if (res_valid1 && res_ready1) begin
        if (res_idx1 == 1'b0) got0 = res_data1;
        else got1 = res_data1;
        gotovf = res_ovf1;
      end
      start1 = (edges == 3);
      @(negedge clk);
      edges++;
    end
    start1 = 1'b0;
    n_checks++;
    if (edges !== EXP_LAT1) begin
      n_errors++;
      $display("FAIL %s_latency: got %0d want %0d", name, edges, EXP_LAT1);
    end
    n_checks++;
    if (busy1 !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_busy_at_done: got %b want 0", name, busy1);
    end
    n_checks++;
    if (got0 !== e0 || got1 !== e1) begin
      n_errors++;
      $display("FAIL %s_words: got %h %h want %h %h", name, got0, got1, e0, e1);
    end
`ifdef MMP_IDDMM_CTRL_FINALSUB_EN
`else
    n_checks++;
    if (gotovf !== eovf) begin
      n_errors++;
      $display("FAIL %s_ovf: got %b want %b", name, gotovf, eovf);
    end
`endif
    // start held during the DONE cycle must be ignored.
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n_checks++;
    if ({busy1, done1} !== 2'b00) begin
      n_errors++;
      $display("FAIL %s_start_in_done: got %b want 00", name, {busy1, done1});
    end
    @(negedge clk);
  endtask

  task automatic test_control_seq();
    // {q_ena, c_pre_clr, carry_clr, carry_ena, carry_sel} for cycles 1..12
    logic [4:0] ec [12] = '{5'b11100, 5'b00100, 5'b00000, 5'b00011,
                            5'b11000, 5'b00000, 5'b00000, 5'b00011,
                            5'b00000, 5'b00000, 5'b00000, 5'b00000};
    logic [1:0] ej [12] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd1, 2'd2,
                            2'd0, 2'd0, 2'd0, 2'd0};
    logic [0:0] ei [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                            1'b1, 1'b1, 1'b1, 1'b1};
    int wait_cnt;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      n_checks++;
      if ({qen2, pre2, clr2, ena2, sel2} !== ec[c] || j_idx2 !== ej[c] ||
          i_idx2 !== ei[c] || busy2 !== 1'b1) begin
        n_errors++;
        $display("FAIL ctl_cycle%0d: got ctl=%b j=%0d i=%0d busy=%b want ctl=%b j=%0d i=%0d busy=1",
                 c + 1, {qen2, pre2, clr2, ena2, sel2}, j_idx2, i_idx2, busy2,
                 ec[c], ej[c], ei[c]);
      end
      @(negedge clk);
    end
    wait_cnt = 0;
    while (!done2 && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    n_checks++;
    if (done2 !== 1'b1) begin
      n_errors++;
      $display("FAIL ctl_done: got %b want 1", done2);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure_reset(input logic [7:0] e0);
    int wait_cnt;
    mode_r     = 2;
    res_ready1 = 1'b0;
    start1     = 1'b1;
    @(negedge clk);
    start1   = 1'b0;
    wait_cnt = 0;
    while (!res_valid1 && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    n_checks++;
    if (res_valid1 !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_valid: got %b want 1", res_valid1);
    end
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (res_valid1 !== 1'b1 || res_idx1 !== 1'b0 || res_data1 !== e0) begin
        n_errors++;
        $display("FAIL bp_stall%0d: got v=%b idx=%0d data=%h want v=1 idx=0 data=%h",
                 c, res_valid1, res_idx1, res_data1, e0);
      end
      if (c < 3) @(negedge clk);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (outs1() !== 32'd0) begin
      n_errors++;
      $display("FAIL bp_reset_outs: got %h want 0", outs1());
    end
    @(negedge clk);
    rst        = 1'b0;
    res_ready1 = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
`ifdef MMP_IDDMM_CTRL_FINALSUB_EN
    test_run(0, 8'h00, 8'h00, 1'b0, "equal");
    test_run(1, 8'h10, 8'h10, 1'b0, "pass");
    test_run(2, 8'h3A, 8'h0F, 1'b0, "subtract");
    test_control_seq();
    test_backpressure_reset(8'h3A);
    test_run(2, 8'h3A, 8'h0F, 1'b0, "after_reset");
`else
    test_run(0, 8'hC5, 8'hF0, 1'b0, "equal");
    test_run(1, 8'h10, 8'h10, 1'b0, "pass");
    test_run(2, 8'hFF, 8'hFF, 1'b1, "subtract");
    test_control_seq();
    test_backpressure_reset(8'hFF);
    test_run(2, 8'hFF, 8'hFF, 1'b1, "after_reset");
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mmp_iddmm_ctrl.md
Name: mmp_iddmm_ctrl

Overview:
- Synthesizable sequencer wrapped around one mmp_iddmm_pe.
- Generates the i/j word loops and the PE control strobes, and owns the (N+1)-word intermediate A buffer.
- Delays j by the PE latency to write uj back into the buffer, captures the final carry into A[N], then performs the conditional final subtraction A-M word-serially.
- Streams the N-word Montgomery result out over a valid/ready port; start/busy/done handshake to the host.

Parameters:
- K, 128, word width in bits.
- N, 32, number of K-bit words in an operand.
- LAT, 16, PE pipeline latency (L1+L2+L3+L4+D5); legal range 1..N.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle request; ignored while busy=1
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the final result word has been accepted
- i_idx  out  $clog2(N)  y-word index to the external y memory
- j_idx  out  $clog2(N)+1  x/m-word index to the external x/m memories (combinational read)
- mj  in  K  m word at j_idx; the block forces index N to 0
- aj  out  K  A[j_idx] to the PE
- uj  in  K  PE result word
- carry  in  1  PE carry
- ctl_carry_clr, ctl_carry_ena, ctl_carry_sel, ctl_c_pre_clr, ctl_q_ena  out  1 each  PE controls
- res_valid  out  1  result word valid
- res_ready  in  1  sink ready
- res_idx  out  $clog2(N)  result word index
- res_data  out  K  result word

Behaviour:
- Reset: FSM=IDLE; busy, done, res_valid=0; i_idx, j_idx, res_idx, res_data=0; all ctl_*=0; A buffer cleared to 0; LAT-deep j delay line cleared to 0.
- Reset mid-operation aborts immediately with no partial output.
- FSM states:
  - IDLE: start -> Q with i=0, j=0, busy=1.
  - Q: one cycle, j=0, j00=1. ctl_c_pre_clr=ctl_q_ena=1; ctl_carry_clr=1 if i==0. -> ROW.
  - ROW: j runs 0..N, one per cycle (N+1 cycles). ctl_carry_clr=(i==0 && j==0); ctl_carry_ena=ctl_carry_sel=(j==N). At j==N: if i==N-1 -> DRAIN, else i++, -> Q.
  - DRAIN: LAT cycles, j_idx held 0. -> CARRY.
  - CARRY: A[N] <= {K-1 zeros, carry}. -> CMP.
  - CMP: j=0..N (N+1 cycles); computes borrow of A-M (M[N]=0); ge = no final borrow. -> OUT.
  - OUT: for j=0..N-1, res_data = ge ? (A[j]-M[j]-b) : A[j], with running borrow b. Advance only on res_valid && res_ready; res_valid/res_data/res_idx are held stable while stalled. -> DONE.
  - DONE: done=1 for one cycle, busy=0, A buffer cleared. -> IDLE.
- Row length is N+2 cycles (j=0 is issued twice: once in Q, once in ROW).
- Write-back: j is issued into the LAT-deep delay line every cycle. When the delayed j_d != 0, A[j_d-1] <= uj.
- Constraint: LAT <= N guarantees the row i write lands before the row i+1 read of the same word.
- Q-cycle and DRAIN-issued zeros never write.
- Subtraction is K-bit plus 1-bit borrow per cycle; no multi-word adders.
- ctl_* are 0 outside Q/ROW.
- start during busy: ignored.
- start in the DONE cycle: ignored.
- Total latency with res_ready=1: N(N+2) + LAT + 1 + (N+1) + N cycles, then done.

Optional Feature:
- MMP_IDDMM_CTRL_FINALSUB_EN:
  - Defined: CMP state and conditional subtraction exist as above.
  - Undefined: CARRY -> OUT directly, res_data = A[j] unconditionally, and an extra output res_ovf (1 bit) = A[N][0] is valid with res_valid. Area saved: the borrow chain and the ge flag.

Test Plan:
- Equal case: K=8, N=2, LAT=1, M=0xF0C5; stub PE drives uj=C5 for write addr 0 and F0 for addr 1, carry=0 -> A=0xF0C5, ge=1, res words 0x00, 0x00; done 15 cycles after start acceptance.
- Pass-through: same config, stub uj=0x10, carry=0 -> A=0x1010<M, res words 0x10, 0x10.
- Subtract: stub uj=0xFF, carry=1 -> A=0x1FFFF, res words 0x3A, 0x0F.
- Control sequence: K=8, N=2, LAT=2, check every cycle of the strobes:
  - ctl_q_ena pulses at cycles 1, 5;
  - ctl_carry_clr at cycles 1, 2;
  - ctl_carry_ena at cycles 4, 8;
  - no A write with j_d=0.
- Backpressure/reset: res_ready low for 3 cycles on word 0 -> res_data stable, res_idx=0; then rst pulsed in OUT -> all outputs 0, next start runs cleanly.
- Full size: K=128, N=32, LAT=16, real mmp_iddmm_pe with the 4096-bit x/y/m/m1 vectors -> streamed result equals x*y*2^(-K*N) mod m from the golden model; start during busy ignored.
